// File: rtl/guess_entry_if.sv
// Guess handshake bundle between the switch-entry stage and the comparator.
// The producer drives guess/guess_valid and the consumer answers with guess_ready.
interface guess_entry_if;
    logic [7:0] guess;
    logic       guess_valid;
    logic       guess_ready;

    modport master (
        output guess,
        output guess_valid,
        input  guess_ready
    );

    modport slave (
        input  guess,
        input  guess_valid,
        output guess_ready
    );
endinterface

// File: rtl/guess_entry.sv
// Switch-bank conditioning: two-flop synchroniser, debouncer, and a valid/ready
// offer of each newly settled value, with a saturating count of accepted guesses.
module guess_entry #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           sw_in,
    guess_entry_if.master        gif,
    output logic                 settling,
    output logic [3:0]           tries,
    output logic                 tries_sat
);

    localparam logic [15:0] DEB_LIMIT = 16'(DEBOUNCE_CYCLES);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    logic [7:0]  sync1_r;
    logic [7:0]  sync2_r;
    logic [7:0]  cand_r;
    logic [7:0]  cand_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic        settling_r;
    logic        stable_s;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  guess_r;
    logic [7:0]  guess_s;
    logic        guess_valid_r;
    logic        guess_valid_s;
    logic [7:0]  last_r;
    logic [7:0]  last_s;
    logic        last_valid_r;
    logic        last_valid_s;
    logic [3:0]  tries_r;
    logic [3:0]  tries_s;
    logic        tries_sat_r;
    logic        acc_r;
    logic        acc_s;

    assign stable_s = (cnt_r == DEB_LIMIT);

    // Debounce next-state: restart on any change, otherwise count up to the limit.
    always_comb begin
        cand_s = cand_r;
        cnt_s  = cnt_r;
        if (sync2_r != cand_r) begin
            cand_s = sync2_r;
            cnt_s  = 16'd0;
        end else if (cnt_r != DEB_LIMIT) begin
            cnt_s = cnt_r + 16'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Synchroniser and debouncer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 8'd0;
            sync2_r    <= 8'd0;
            cand_r     <= 8'd0;
            cnt_r      <= 16'd0;
            settling_r <= 1'b1;
        end else begin
            sync1_r    <= sw_in;
            sync2_r    <= sync1_r;
            cand_r     <= cand_s;
            cnt_r      <= cnt_s;
            settling_r <= (cnt_s != DEB_LIMIT);
        end
    end

    // Offer FSM next-state and datapath; acc_s blocks an offer on the cycle right after an acceptance.
    always_comb begin
        state_s       = state_r;
        guess_s       = guess_r;
        guess_valid_s = guess_valid_r;
        last_s        = last_r;
        last_valid_s  = last_valid_r;
        tries_s       = tries_r;
        acc_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (!acc_r && stable_s && (!last_valid_r || (cand_r != last_r))) begin
                    state_s       = OFFER;
                    guess_s       = cand_r;
                    guess_valid_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OFFER: begin
                if (guess_valid_r && gif.guess_ready) begin
                    state_s       = IDLE;
                    guess_valid_s = 1'b0;
                    last_s        = guess_r;
                    last_valid_s  = 1'b1;
                    acc_s         = 1'b1;
                    if (tries_r != 4'd15) begin
                        tries_s = tries_r + 4'd1;
                    end else begin
                        tries_s = tries_r;
                    end
                end else begin
                    state_s = OFFER;
                end
            end
            default: begin
                state_s       = IDLE;
                guess_valid_s = 1'b0;
            end
        endcase
    end

    // Offer FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            guess_r       <= 8'd0;
            guess_valid_r <= 1'b0;
            last_r        <= 8'd0;
            last_valid_r  <= 1'b0;
            tries_r       <= 4'd0;
            tries_sat_r   <= 1'b0;
            acc_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            guess_r       <= guess_s;
            guess_valid_r <= guess_valid_s;
            last_r        <= last_s;
            last_valid_r  <= last_valid_s;
            tries_r       <= tries_s;
            tries_sat_r   <= (tries_s == 4'd15);
            acc_r         <= acc_s;
        end
    end

    assign gif.guess       = guess_r;
    assign gif.guess_valid = guess_valid_r;
    assign settling        = settling_r;
    assign tries           = tries_r;
    assign tries_sat       = tries_sat_r;

endmodule
